// File: rtl/banco_registradores_param_if.sv
// Port bundle for banco_registradores_param: read ports, register write,
// reservation (scoreboard) and boolean-flag access.
interface banco_registradores_param_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 3,
    parameter int BADDR = 2
);
    logic               Halt;
    logic [ADDR-1:0]    RegLido1;
    logic [ADDR-1:0]    RegLido2;
    logic [WIDTH-1:0]   Dado1;
    logic [WIDTH-1:0]   Dado2;
    logic               Ocupado1;
    logic               Ocupado2;
    logic               EscreveReg;
    logic [ADDR-1:0]    RegEscrito;
    logic [WIDTH-1:0]   DadoEscrito;
    logic               Reserva;
    logic [ADDR-1:0]    RegReservado;
    logic               ReservaOk;
    logic [ADDR:0]      NumOcupados;
    logic [BADDR-1:0]   BoolLido1;
    logic [BADDR-1:0]   BoolLido2;
    logic               DadoBool1;
    logic               DadoBool2;
    logic               EscreveBool;
    logic [BADDR-1:0]   BoolEscrito;
    logic               DadoBoolEscrito;

    modport master (
        output Halt, RegLido1, RegLido2, EscreveReg, RegEscrito, DadoEscrito,
               Reserva, RegReservado, BoolLido1, BoolLido2, EscreveBool,
               BoolEscrito, DadoBoolEscrito,
        input  Dado1, Dado2, Ocupado1, Ocupado2, ReservaOk, NumOcupados,
               DadoBool1, DadoBool2
    );

    modport slave (
        input  Halt, RegLido1, RegLido2, EscreveReg, RegEscrito, DadoEscrito,
               Reserva, RegReservado, BoolLido1, BoolLido2, EscreveBool,
               BoolEscrito, DadoBoolEscrito,
        output Dado1, Dado2, Ocupado1, Ocupado2, ReservaOk, NumOcupados,
               DadoBool1, DadoBool2
    );
endinterface

// File: rtl/banco_registradores_param.sv
// Register file with write bypass, per-register busy (reservation) bits,
// a registered busy count, and a small boolean-flag bank.
module banco_registradores_param #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 3,
    parameter int BADDR = 2
) (
    input  logic                        Clock,
    input  logic                        Reset,
    banco_registradores_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR;
    localparam int NBOOL = 2 ** BADDR;

    logic [WIDTH-1:0] bancoR [DEPTH];
    logic [DEPTH-1:0] busyR;
    logic [NBOOL-1:0] flagR;
    logic [ADDR:0]    countR;

    logic             writeEffS;
    logic             boolEffS;
    logic             sameWrResS;
    logic             grantS;
    logic             incS;
    logic             decS;
    logic [WIDTH-1:0] dado1S;
    logic [WIDTH-1:0] dado2S;
    logic             ocupado1S;
    logic             ocupado2S;
    logic             dadoBool1S;
    logic             dadoBool2S;

    // Qualify writes/reservations and derive the busy-count delta.
    // During reset nothing is effective, so outputs reflect stored state only.
    always_comb begin
        writeEffS  = bus.EscreveReg & ~bus.Halt & Reset;
        boolEffS   = bus.EscreveBool & ~bus.Halt & Reset;
        sameWrResS = writeEffS & (bus.RegEscrito == bus.RegReservado);
        grantS     = bus.Reserva & ~bus.Halt & Reset &
                     (~busyR[bus.RegReservado] | sameWrResS);
        // Count rises only on a 0->1 transition; a write to a busy register
        // that is re-reserved in the same cycle leaves the bit (and count) at 1.
        incS       = grantS & ~busyR[bus.RegReservado];
        decS       = writeEffS & busyR[bus.RegEscrito] & ~(grantS & sameWrResS);
    end

    // Register read ports with same-cycle write bypass and stall flags.
    always_comb begin
        if (writeEffS && (bus.RegEscrito == bus.RegLido1)) begin
            dado1S    = bus.DadoEscrito;
            ocupado1S = 1'b0;
        end else begin
            dado1S    = bancoR[bus.RegLido1];
            ocupado1S = busyR[bus.RegLido1];
        end
        if (writeEffS && (bus.RegEscrito == bus.RegLido2)) begin
            dado2S    = bus.DadoEscrito;
            ocupado2S = 1'b0;
        end else begin
            dado2S    = bancoR[bus.RegLido2];
            ocupado2S = busyR[bus.RegLido2];
        end
    end

    // Flag read ports with same-cycle write bypass.
    always_comb begin
        if (boolEffS && (bus.BoolEscrito == bus.BoolLido1)) begin
            dadoBool1S = bus.DadoBoolEscrito;
        end else begin
            dadoBool1S = flagR[bus.BoolLido1];
        end
        if (boolEffS && (bus.BoolEscrito == bus.BoolLido2)) begin
            dadoBool2S = bus.DadoBoolEscrito;
        end else begin
            dadoBool2S = flagR[bus.BoolLido2];
        end
    end

    // State update: reset wins over everything, Halt freezes all state.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bancoR[i] <= '0;
            end
            busyR  <= '0;
            flagR  <= '0;
            countR <= '0;
        end else if (!bus.Halt) begin
            if (writeEffS) begin
                bancoR[bus.RegEscrito] <= bus.DadoEscrito;
                busyR[bus.RegEscrito]  <= 1'b0;
            end
            // Placed after the write clear so a same-address grant leaves busy=1.
            if (grantS) begin
                busyR[bus.RegReservado] <= 1'b1;
            end
            if (boolEffS) begin
                flagR[bus.BoolEscrito] <= bus.DadoBoolEscrito;
            end
            countR <= countR + {{ADDR{1'b0}}, incS} - {{ADDR{1'b0}}, decS};
        end else begin
            countR <= countR;
        end
    end

    assign bus.Dado1       = dado1S;
    assign bus.Dado2       = dado2S;
    assign bus.Ocupado1    = ocupado1S;
    assign bus.Ocupado2    = ocupado2S;
    assign bus.ReservaOk   = grantS;
    assign bus.NumOcupados = countR;
    assign bus.DadoBool1   = dadoBool1S;
    assign bus.DadoBool2   = dadoBool2S;
endmodule

// File: doc/banco_registradores_param.md
BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

Interface
Parameters: name, default, meaning.
REQ-001 SHALL: WIDTH, 8, data register width in bits.
REQ-002 SHALL: ADDR, 3, register address width; DEPTH = 2**ADDR registers.
REQ-003 SHALL: BADDR, 2, boolean-flag address width; 2**BADDR flags.

Ports: name, direction, width, meaning.
REQ-004 SHALL: Clock  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL: Reset  in  1  synchronous, active-low reset.
REQ-006 SHALL: Halt  in  1  freezes all state updates while 1.
REQ-007 SHALL: RegLido1, RegLido2  in  ADDR  read-port addresses.
REQ-008 SHALL: Dado1, Dado2  out  WIDTH  read data.
REQ-009 SHALL: Ocupado1, Ocupado2  out  1  read register awaiting result (stall).
REQ-010 SHALL: EscreveReg  in  1  write enable; RegEscrito in ADDR; DadoEscrito in WIDTH.
REQ-011 SHALL: Reserva  in  1  reserve request; RegReservado in ADDR  register to mark busy.
REQ-012 SHALL: ReservaOk  out  1  reservation granted this cycle.
REQ-013 SHALL: NumOcupados  out  ADDR+1  registered count of busy registers.
REQ-014 SHALL: BoolLido1, BoolLido2  in  BADDR; DadoBool1, DadoBool2  out  1  flag reads.
REQ-015 SHALL: EscreveBool  in  1; BoolEscrito  in  BADDR; DadoBoolEscrito  in  1  flag write.

Function
REQ-016 SHALL: Reads are combinational; DadoN = banco[RegLidoN], DadoBoolN = flag[BoolLidoN].
REQ-017 SHALL: Write bypass: if the write is effective (EscreveReg=1, Halt=0) and RegEscrito==RegLidoN, DadoN = DadoEscrito in the same cycle; the same applies to flags.
REQ-018 SHALL: OcupadoN = busy[RegLidoN] AND NOT (effective write to RegLidoN this cycle).
REQ-019 SHALL: Effective write updates banco[RegEscrito] and clears busy[RegEscrito] at the edge; a write to a non-busy register is legal and busy stays 0.
REQ-020 SHALL: ReservaOk = Reserva AND NOT Halt AND (busy[RegReservado]=0 OR effective write to RegReservado this cycle); combinational.
REQ-021 SHALL: On ReservaOk, busy[RegReservado] is set to 1 at the edge.
REQ-022 SHALL: Simultaneous write and granted reserve to the same address: data is written, and the final busy bit is 1.
REQ-023 SHALL: A denied reservation (busy, no same-cycle write) changes no state.
REQ-024 SHALL: NumOcupados = previous count + granted set − cleared busy bits, updated every edge and never wrapping; range 0..DEPTH.
REQ-025 SHALL: Effective flag write (EscreveBool=1, Halt=0) updates flag[BoolEscrito].
REQ-026 SHALL: While Halt=1, no register, flag, busy bit or count changes; reads and bypass-free outputs remain valid; ReservaOk = 0.
REQ-027 SHALL: All register addresses are writable; register 0 is not special.

Reset
REQ-028 SHALL: When Reset=0 at a rising edge, all banco entries, flags, busy bits and NumOcupados become 0.
REQ-029 SHALL: Reset overrides Halt, EscreveReg, Reserva and EscreveBool in the same cycle.
REQ-030 SHALL: During Reset=0, combinational outputs follow the current state, and ReservaOk is forced to 0.
REQ-031 SHALL: Reset mid-reservation discards all pending reservations; no late clear is required.

Verification
REQ-032 SHALL: Reset, then write 0xA5 to r3, read r3 -> Dado1=0xA5 on the write cycle (bypass) and after it; Ocupado1=0.
REQ-033 SHALL: Reserve r5 -> ReservaOk=1, NumOcupados=1, Ocupado2=1 for RegLido2=5; reserve r5 again -> ReservaOk=0, count stays 1.
REQ-034 SHALL: r5 busy; write 0x3C to r5 with reserve r5 in the same cycle -> ReservaOk=1, r5=0x3C, busy[5]=1, count stays 1.
REQ-035 SHALL: Halt=1 with write r2=0xFF, reserve r1 and flag write f1=1 -> r2, busy, count and f1 unchanged; ReservaOk=0.
REQ-036 SHALL: Reserve all DEPTH registers -> NumOcupados=DEPTH; Reset=0 for 1 cycle with Halt=1 -> all state 0 and count 0.
REQ-037 SHALL: WIDTH=16, ADDR=4 build: write 0xBEEF to r15, read it back -> 0xBEEF; NumOcupados is 5 bits wide.
